// File: rtl/mem_write_arbiter.sv
// Write-port arbiter: two write clients share one memory-controller write port.
// Video reads can hold off a pending write for up to MAX_DEFER idle cycles.
module mem_write_arbiter #(
    parameter int unsigned MAX_DEFER   = 255,
    parameter int unsigned DEFER_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        c0_wr_request,
    input  logic [22:0] c0_wr_address,
    input  logic [31:0] c0_wr_data,
    input  logic [3:0]  c0_wr_mask,
    input  logic [8:0]  c0_wr_burst_length,
    output logic        c0_wr_done,

    input  logic        c1_wr_request,
    input  logic [22:0] c1_wr_address,
    input  logic [31:0] c1_wr_data,
    input  logic [3:0]  c1_wr_mask,
    input  logic [8:0]  c1_wr_burst_length,
    output logic        c1_wr_done,

    input  logic        rd_request,

    output logic        wr_request,
    output logic [22:0] wr_address,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_mask,
    output logic [8:0]  wr_burst_length,
    input  logic        wr_done,

    output logic [1:0]  grant
);

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1, StRelease} state_e;

    localparam logic [DEFER_WIDTH-1:0] MaxDefer = DEFER_WIDTH'(MAX_DEFER);

    state_e                 state_q, state_d;
    logic [1:0]             grant_q, grant_d;
    logic                   last_q, last_d;   // 1: client 1 was granted last
    logic [DEFER_WIDTH-1:0] defer_q, defer_d;

    // Next-state logic: arbitration, video-read holdoff and grant release.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        defer_d = defer_q;
        unique case (state_q)
            StIdle: begin
                if (c0_wr_request || c1_wr_request) begin
                    if (rd_request && (defer_q < MaxDefer)) begin
                        defer_d = defer_q + DEFER_WIDTH'(1);
                    end else begin
                        defer_d = '0;
                        // Client 0 wins when alone, or on a tie if client 1 went last.
                        if (c0_wr_request && (!c1_wr_request || last_q)) begin
                            state_d = StGrant0;
                            last_d  = 1'b0;
                        end else begin
                            state_d = StGrant1;
                            last_d  = 1'b1;
                        end
                    end
                end else begin
                    defer_d = '0;
                end
            end
            StGrant0:  if (wr_done) state_d = StRelease;
            StGrant1:  if (wr_done) state_d = StRelease;
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        grant_d = 2'b00;
        if (state_d == StGrant0) grant_d = 2'b01;
        if (state_d == StGrant1) grant_d = 2'b10;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            defer_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            defer_q <= defer_d;
        end
    end

    // Output mux; gated by rst_n so a reset aborts ownership in the same cycle.
    always_comb begin
        wr_request      = 1'b0;
        wr_address      = '0;
        wr_data         = '0;
        wr_mask         = '0;
        wr_burst_length = '0;
        c0_wr_done      = 1'b0;
        c1_wr_done      = 1'b0;
        if (rst_n) begin
            case (state_q)
                StGrant0: begin
                    wr_request      = 1'b1;
                    wr_address      = c0_wr_address;
                    wr_data         = c0_wr_data;
                    wr_mask         = c0_wr_mask;
                    wr_burst_length = c0_wr_burst_length;
                    c0_wr_done      = wr_done;
                end
                StGrant1: begin
                    wr_request      = 1'b1;
                    wr_address      = c1_wr_address;
                    wr_data         = c1_wr_data;
                    wr_mask         = c1_wr_mask;
                    wr_burst_length = c1_wr_burst_length;
                    c1_wr_done      = wr_done;
                end
                default: ;
            endcase
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Self-checking bench for mem_write_arbiter (MAX_DEFER overridden to 4).
module tb_mem_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c0_wr_request, c1_wr_request, rd_request, wr_done;
    logic [22:0] c0_wr_address, c1_wr_address, wr_address;
    logic [31:0] c0_wr_data, c1_wr_data, wr_data;
    logic [3:0]  c0_wr_mask, c1_wr_mask, wr_mask;
    logic [8:0]  c0_wr_burst_length, c1_wr_burst_length, wr_burst_length;
    logic        c0_wr_done, c1_wr_done, wr_request;
    logic [1:0]  grant;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_write_arbiter #(.MAX_DEFER(4), .DEFER_WIDTH(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .c0_wr_request      (c0_wr_request),
        .c0_wr_address      (c0_wr_address),
        .c0_wr_data         (c0_wr_data),
        .c0_wr_mask         (c0_wr_mask),
        .c0_wr_burst_length (c0_wr_burst_length),
        .c0_wr_done         (c0_wr_done),
        .c1_wr_request      (c1_wr_request),
        .c1_wr_address      (c1_wr_address),
        .c1_wr_data         (c1_wr_data),
        .c1_wr_mask         (c1_wr_mask),
        .c1_wr_burst_length (c1_wr_burst_length),
        .c1_wr_done         (c1_wr_done),
        .rd_request         (rd_request),
        .wr_request         (wr_request),
        .wr_address         (wr_address),
        .wr_data            (wr_data),
        .wr_mask            (wr_mask),
        .wr_burst_length    (wr_burst_length),
        .wr_done            (wr_done),
        .grant              (grant)
    );

    typedef struct {
        logic        c0, c1, rd, done;
        logic        exp_req;
        logic [1:0]  exp_grant;
        logic        exp_d0, exp_d1;
        logic [22:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    function automatic vec_t mk(logic c0, logic c1, logic rd, logic done, logic req,
                                logic [1:0] g, logic d0, logic d1,
                                logic [22:0] addr, logic [31:0] data);
        vec_t v;
        v.c0 = c0; v.c1 = c1; v.rd = rd; v.done = done;
        v.exp_req = req; v.exp_grant = g; v.exp_d0 = d0; v.exp_d1 = d1;
        v.exp_addr = addr; v.exp_data = data;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        c0_wr_request = 1'b0; c1_wr_request = 1'b0; rd_request = 1'b0; wr_done = 1'b0;
        c0_wr_address = 23'h000100; c0_wr_data = 32'hDEADBEEF;
        c0_wr_mask = 4'hF; c0_wr_burst_length = 9'd1;
        c1_wr_address = 23'h000200; c1_wr_data = 32'h12345678;
        c1_wr_mask = 4'h3; c1_wr_burst_length = 9'd8;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    vec_t vecs[17];

    initial begin
        logic [1:0] obs [4];
        int         gaps [4];
        int         n, in_cnt, zero_run, found;
        logic [1:0] prev;
        logic [31:0] beat_data;

        // Table: inputs applied this cycle, outputs expected this cycle.
        vecs[0]  = mk(1,0,0,0, 0,2'b00,0,0, 23'h0,   32'h0);
        vecs[1]  = mk(1,0,0,0, 1,2'b01,0,0, 23'h100, 32'hDEADBEEF);
        vecs[2]  = mk(1,0,0,0, 1,2'b01,0,0, 23'h100, 32'hDEADBEEF);
        vecs[3]  = mk(1,0,0,0, 1,2'b01,0,0, 23'h100, 32'hDEADBEEF);
        vecs[4]  = mk(1,0,0,0, 1,2'b01,0,0, 23'h100, 32'hDEADBEEF);
        vecs[5]  = mk(1,0,0,0, 1,2'b01,0,0, 23'h100, 32'hDEADBEEF);
        vecs[6]  = mk(1,0,0,1, 1,2'b01,1,0, 23'h100, 32'hDEADBEEF);
        vecs[7]  = mk(0,0,0,0, 0,2'b00,0,0, 23'h0,   32'h0);
        vecs[8]  = mk(0,0,0,1, 0,2'b00,0,0, 23'h0,   32'h0);
        vecs[9]  = mk(0,0,0,0, 0,2'b00,0,0, 23'h0,   32'h0);
        vecs[10] = mk(1,1,0,0, 0,2'b00,0,0, 23'h0,   32'h0);
        vecs[11] = mk(1,1,0,0, 1,2'b10,0,0, 23'h200, 32'h12345678);
        vecs[12] = mk(1,1,0,1, 1,2'b10,0,1, 23'h200, 32'h12345678);
        vecs[13] = mk(1,1,0,0, 0,2'b00,0,0, 23'h0,   32'h0);
        vecs[14] = mk(1,1,0,0, 0,2'b00,0,0, 23'h0,   32'h0);
        vecs[15] = mk(1,1,0,0, 1,2'b01,0,0, 23'h100, 32'hDEADBEEF);
        vecs[16] = mk(1,1,0,1, 1,2'b01,1,0, 23'h100, 32'hDEADBEEF);

        do_reset();
        #3;
        check("reset wr_request", wr_request, 1'b0);
        check("reset grant", grant, 2'b00);
        check("reset c0_wr_done", c0_wr_done, 1'b0);
        check("reset c1_wr_done", c1_wr_done, 1'b0);
        check("reset wr_address", wr_address, 23'h0);
        tick();

        for (int i = 0; i < 17; i++) begin
            c0_wr_request = vecs[i].c0;
            c1_wr_request = vecs[i].c1;
            rd_request    = vecs[i].rd;
            wr_done       = vecs[i].done;
            #3;
            check($sformatf("vec%0d wr_request", i), wr_request, vecs[i].exp_req);
            check($sformatf("vec%0d grant", i), grant, vecs[i].exp_grant);
            check($sformatf("vec%0d c0_wr_done", i), c0_wr_done, vecs[i].exp_d0);
            check($sformatf("vec%0d c1_wr_done", i), c1_wr_done, vecs[i].exp_d1);
            check($sformatf("vec%0d wr_address", i), wr_address, vecs[i].exp_addr);
            check($sformatf("vec%0d wr_data", i), wr_data, vecs[i].exp_data);
            tick();
        end

        // Fairness from reset: both hold requests, each grant completes on its third cycle.
        do_reset();
        c0_wr_request = 1'b1;
        c1_wr_request = 1'b1;
        n = 0; in_cnt = 0; zero_run = 0; prev = 2'b00;
        for (int cyc = 0; cyc < 80 && n < 4; cyc++) begin
            wr_done = (grant != 2'b00) && (in_cnt == 2);
            #3;
            if (grant != 2'b00) begin
                if (prev == 2'b00) begin
                    obs[n] = grant;
                    gaps[n] = zero_run;
                    n++;
                end
                in_cnt++;
                zero_run = 0;
            end else begin
                in_cnt = 0;
                zero_run++;
            end
            prev = grant;
            tick();
        end
        wr_done = 1'b0;
        check("rr grant count", 64'(n), 64'd4);
        if (n == 4) begin
            check("rr grant 0", obs[0], 2'b01);
            check("rr grant 1", obs[1], 2'b10);
            check("rr grant 2", obs[2], 2'b01);
            check("rr grant 3", obs[3], 2'b10);
            // Idle gap is the RELEASE cycle plus the IDLE arbitration cycle.
            for (int k = 1; k < 4; k++) check($sformatf("rr gap %0d", k), 64'(gaps[k]), 64'd2);
        end

        // Holdoff saturates: 4 deferred cycles then grant despite rd_request.
        do_reset();
        rd_request = 1'b1;
        c1_wr_request = 1'b1;
        found = -1;
        for (int cyc = 0; cyc < 20 && found < 0; cyc++) begin
            #3;
            if (wr_request) found = cyc;
            else tick();
        end
        check("defer first wr_request cycle", 64'(found), 64'd5);
        check("defer grant", grant, 2'b10);

        // Holdoff released early when rd_request drops.
        do_reset();
        rd_request = 1'b1;
        c1_wr_request = 1'b1;
        #3; check("early cyc0 wr_request", wr_request, 1'b0); tick();
        #3; check("early cyc1 wr_request", wr_request, 1'b0); tick();
        rd_request = 1'b0;
        #3; check("early cyc2 wr_request", wr_request, 1'b0); tick();
        #3; check("early cyc3 wr_request", wr_request, 1'b1);
        check("early cyc3 grant", grant, 2'b10);
        check("burst length", wr_burst_length, 9'd8);
        check("burst mask", wr_mask, 4'h3);

        // Burst of 8 on client 1: data passes through in the same cycle.
        for (int b = 0; b < 8; b++) begin
            beat_data = 32'hA5000000 | 32'(b * 17);
            c1_wr_data = beat_data;
            wr_done = (b == 7);
            #1;
            check($sformatf("burst beat%0d wr_data", b), wr_data, beat_data);
            check($sformatf("burst beat%0d c1_wr_done", b), c1_wr_done, (b == 7));
            #2;
            tick();
        end
        wr_done = 1'b0;
        c1_wr_request = 1'b0;
        #3;
        check("burst release wr_request", wr_request, 1'b0);
        check("burst release grant", grant, 2'b00);

        // Reset coincident with wr_done during GRANT0.
        do_reset();
        c0_wr_request = 1'b1;
        tick();
        #3;
        check("rstgrant pre grant", grant, 2'b01);
        check("rstgrant mask", wr_mask, 4'hF);
        check("rstgrant burst", wr_burst_length, 9'd1);
        rst_n = 1'b0;
        wr_done = 1'b1;
        #1;
        check("rstgrant c0_wr_done", c0_wr_done, 1'b0);
        check("rstgrant wr_request", wr_request, 1'b0);
        check("rstgrant wr_address", wr_address, 23'h0);
        tick();
        rst_n = 1'b1;
        wr_done = 1'b0;
        c1_wr_request = 1'b1;
        #3;
        check("rstgrant after grant", grant, 2'b00);
        check("rstgrant after wr_request", wr_request, 1'b0);
        tick();
        #3;
        check("rstgrant rearb grant", grant, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
